// File: rtl/ifetch_buffer.sv
// Instruction fetch unit: issues sequential imem reads and queues tagged responses for decode.
// Define IFB_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_buffer #(
    parameter int unsigned N     = 16,
    parameter int unsigned AW    = N - 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [N-1:0]  imem_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [N-1:0]  inst_data,
    output logic [AW-1:0] inst_pc
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW + 2)'(DEPTH);
    localparam logic [AW-1:0] PC_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    typedef enum logic {StIdle, StFetch} state_e;

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] r_req_pc;
    logic          r_inflight;
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    logic [N-1:0]  r_q_data [DEPTH];
    logic [AW-1:0] r_q_pc   [DEPTH];

    logic          w_nonempty;
    logic [PW+1:0] w_occ;
    logic          w_issue;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_state_d  = start ? StFetch : StIdle;
        w_nonempty = (r_count != '0);
        // Count the response in flight so the queue can never be oversubscribed.
        w_occ      = {1'b0, r_count} + {{(PW + 1){1'b0}}, r_inflight};
        w_issue    = (r_state == StFetch) && (w_occ < DEPTH_W) && !redirect && !reset;
`ifdef IFB_BYPASS_EN
        w_bypass   = r_inflight && !w_nonempty && !redirect;
`else
        w_bypass   = 1'b0;
`endif
        w_push     = r_inflight && !redirect && !(w_bypass && inst_ready);
        w_pop      = w_nonempty && !redirect && inst_ready;
    end

    always_comb begin
        imem_en    = w_issue;
        imem_addr  = reset ? '0 : r_fetch_pc;
        inst_valid = 1'b0;
        inst_data  = '0;
        inst_pc    = '0;
        if (!reset && !redirect) begin
            if (w_nonempty) begin
                inst_valid = 1'b1;
                inst_data  = r_q_data[r_rptr];
                inst_pc    = r_q_pc[r_rptr];
            end
`ifdef IFB_BYPASS_EN
            else if (w_bypass) begin
                inst_valid = 1'b1;
                inst_data  = imem_data;
                inst_pc    = r_req_pc;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_fetch_pc <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + PC_ONE;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_q_data[r_wptr] <= imem_data;
            r_q_pc[r_wptr]   <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed self-checking bench for ifetch_buffer; a behavioural imem answers addr+0x100.
module tb_ifetch_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        redirect;
    logic [12:0] redirect_pc;
    logic        imem_en;
    logic [12:0] imem_addr;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [12:0] inst_pc;

    int checks = 0;
    int errors = 0;

`ifdef IFB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    ifetch_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        rdy;
        logic        en;
        logic [12:0] addr;
        logic        valid;
        logic [12:0] pc;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [15:0] resp(input logic [12:0] a);
        return {3'b000, a} + 16'h0100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; the memory model answers the request seen this cycle on the next one.
    task automatic cyc();
        logic        en;
        logic [12:0] a;
        en = imem_en;
        a  = imem_addr;
        @(posedge clk);
        #1;
        imem_data = en ? resp(a) : 16'hDEAD;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " en"},    imem_en,    0);
        chk({name, " addr"},  imem_addr,  0);
        chk({name, " valid"}, inst_valid, 0);
        chk({name, " data"},  inst_data,  0);
        chk({name, " pc"},    inst_pc,    0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        imem_data   = 16'hDEAD;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int          n_issue;
        int          nvalid;
        logic        seen;
        logic [12:0] first_addr;
        logic [12:0] wrap_addr[3];

        for (int i = 0; i < 8; i++) begin
            tbl[i].start = 1'b1;
            tbl[i].rdy   = 1'b1;
            tbl[i].en    = (i >= 1);
            tbl[i].addr  = (i >= 1) ? 13'(i - 1) : 13'd0;
            tbl[i].valid = (i >= 1 + LAT);
            tbl[i].pc    = tbl[i].valid ? 13'(i - 1 - LAT) : 13'd0;
            tbl[i].data  = tbl[i].valid ? resp(tbl[i].pc) : 16'd0;
        end
        wrap_addr[0] = 13'h1FFE;
        wrap_addr[1] = 13'h1FFF;
        wrap_addr[2] = 13'h0000;

        // Reset: outputs quiet during and right after reset.
        reset = 1'b1; start = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        imem_data = 16'hDEAD;
        #1;
        chk_quiet("during reset");
        do_reset();
        #1;
        chk_quiet("after reset");

        // Streaming fetch with decode always ready.
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start; inst_ready = tbl[i].rdy;
            #1;
            chk($sformatf("stream%0d en", i),    imem_en,    tbl[i].en);
            chk($sformatf("stream%0d addr", i),  imem_addr,  tbl[i].addr);
            chk($sformatf("stream%0d valid", i), inst_valid, tbl[i].valid);
            chk($sformatf("stream%0d pc", i),    inst_pc,    tbl[i].pc);
            chk($sformatf("stream%0d data", i),  inst_data,  tbl[i].data);
            cyc();
        end

        // Back-pressure: exactly DEPTH requests, then in-order drain and issue resumes at 4.
        do_reset();
        start = 1'b1; inst_ready = 1'b0; n_issue = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (imem_en) begin
                chk("stall addr", imem_addr, 13'(n_issue));
                n_issue++;
            end
            cyc();
        end
        #1;
        chk("stall issues", n_issue, 4);
        chk("stall en held", imem_en, 0);
        chk("stall head valid", inst_valid, 1);
        inst_ready = 1'b1; seen = 1'b0; first_addr = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d valid", k), inst_valid, 1);
            chk($sformatf("drain%0d pc", k),    inst_pc,    13'(k));
            chk($sformatf("drain%0d data", k),  inst_data,  resp(13'(k)));
            if (imem_en && !seen) begin
                seen = 1'b1;
                first_addr = imem_addr;
            end
            cyc();
        end
        chk("resume seen", seen, 1);
        chk("resume addr", first_addr, 13'd4);

        // Redirect with 2 queued and 1 in flight.
        do_reset();
        start = 1'b1; inst_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            cyc();
        end
        #1;
        chk("pre-redir valid", inst_valid, 1);
        redirect = 1'b1; redirect_pc = 13'h0A0;
        #1;
        chk("redir valid", inst_valid, 0);
        chk("redir en", imem_en, 0);
        cyc();
        redirect = 1'b0; inst_ready = 1'b1;
        #1;
        chk("post-redir en", imem_en, 1);
        chk("post-redir addr", imem_addr, 13'h0A0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (inst_valid) begin
                chk("redir stale", (inst_pc < 13'h0A0), 0);
                if (!seen) begin
                    chk("redir first pc", inst_pc, 13'h0A0);
                    chk("redir first data", inst_data, 16'h01A0);
                end
                seen = 1'b1;
            end
            cyc();
        end
        chk("redir delivered", seen, 1);

        // Address wrap at 2^AW.
        redirect = 1'b1; redirect_pc = 13'h1FFE;
        #1;
        cyc();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("wrap%0d en", k),   imem_en,   1);
            chk($sformatf("wrap%0d addr", k), imem_addr, wrap_addr[k]);
            cyc();
        end

        // Start dropped after one issue: that response still arrives, nothing more issued.
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        #1;
        cyc();
        start = 1'b0;
        #1;
        chk("drop en", imem_en, 1);
        chk("drop addr", imem_addr, 0);
        cyc();
        nvalid = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("drop idle%0d en", c), imem_en, 0);
            if (inst_valid) begin
                chk("drop pc", inst_pc, 0);
                chk("drop data", inst_data, 16'h0100);
                nvalid++;
            end
            cyc();
        end
        chk("drop delivered once", nvalid, 1);

        // Reset with a full pipeline and a response arriving.
        do_reset();
        start = 1'b1; inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            cyc();
        end
        #1;
        chk("full head valid", inst_valid, 1);
        reset = 1'b1;
        #1;
        chk_quiet("mid reset");
        cyc();
        reset = 1'b0; start = 1'b0; inst_ready = 1'b1;
        imem_data = 16'h1234;
        #1;
        chk_quiet("post mid reset");
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk($sformatf("late resp%0d valid", c), inst_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
